// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction cache's tag, frame and
// controller state types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef logic [25:0] icache_tag_t;

  typedef struct packed {
    logic        valid;
    icache_tag_t tag;
    word_t [1:0] data;
  } icache_frame_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL0,
    FILL1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Two-way set-associative read-only instruction cache with two-word blocks;
// hits are combinational, misses fill a block from memory and then replay.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 3;

  icache_frame_t       frames [2][SETS];
  logic [SETS-1:0]     lru;
  icache_state_t       state, next_state;

  logic [TAG_W-1:0]    addr_tag;
  logic [IDX_W-1:0]    addr_idx;
  logic                word_sel;
  logic                hit0, hit1, hit_way, victim;

  logic [TAG_W-1:0]    fill_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic                fill_way;

  logic                unused_byte_bits;

  assign addr_tag         = imemaddr[31:IDX_W+3];
  assign addr_idx         = imemaddr[IDX_W+2:3];
  assign word_sel         = imemaddr[2];
  assign unused_byte_bits = ^imemaddr[1:0];

  assign hit0    = frames[0][addr_idx].valid && (frames[0][addr_idx].tag == icache_tag_t'(addr_tag));
  assign hit1    = frames[1][addr_idx].valid && (frames[1][addr_idx].tag == icache_tag_t'(addr_tag));
  assign hit_way = !hit0;
  assign ihit    = imemREN && (state == IDLE) && (hit0 || hit1);
  assign imemload = ihit ? frames[hit_way][addr_idx].data[word_sel] : '0;

  // Fill an empty way first (way 0 before way 1); otherwise evict the LRU way.
  assign victim = !frames[0][addr_idx].valid ? 1'b0 :
                  !frames[1][addr_idx].valid ? 1'b1 : lru[addr_idx];

  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    iaddr      = '0;
    case (state)
      IDLE: begin
        if (imemREN && !ihit) next_state = FILL0;
      end
      FILL0: begin
        iREN  = 1'b1;
        iaddr = {fill_tag, fill_idx, 1'b0, 2'b00};
        if (!iwait) next_state = FILL1;
      end
      FILL1: begin
        iREN  = 1'b1;
        iaddr = {fill_tag, fill_idx, 1'b1, 2'b00};
        if (!iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The victim is invalidated at miss time so an interrupted fill never leaves
  // a half-written block that could later hit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      lru   <= '0;
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < SETS; s++)
          frames[w][s].valid <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (ihit) begin
            lru[addr_idx] <= ~hit_way;
          end else if (imemREN) begin
            fill_tag <= addr_tag;
            fill_idx <= addr_idx;
            fill_way <= victim;
            frames[victim][addr_idx].valid <= 1'b0;
          end
        end
        FILL0: begin
          if (!iwait) frames[fill_way][fill_idx].data[0] <= iload;
        end
        FILL1: begin
          if (!iwait) begin
            frames[fill_way][fill_idx].data[1] <= iload;
            frames[fill_way][fill_idx].tag     <= icache_tag_t'(fill_tag);
            frames[fill_way][fill_idx].valid   <= 1'b1;
            lru[fill_idx]                      <= ~fill_way;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory model answers with {16'hDEAD, addr[15:0]}
// after a programmable number of wait cycles per word.
module tb_icache;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        nRst;
  logic        imemRen;
  logic [31:0] imemAddr;
  logic        ihit;
  logic [31:0] imemLoad;
  logic        iRen;
  logic [31:0] iAddr;
  logic        iWait;
  logic [31:0] iLoad;

  int errors = 0;
  int checks = 0;
  int waitCycles = 0;
  int waitCnt = 0;
  int renCount = 0;
  int renBase;
  int logBase;
  logic [31:0] addrLog[$];

  always #5 clk = ~clk;

  icache dut (
    .CLK(clk),
    .nRST(nRst),
    .imemREN(imemRen),
    .imemaddr(imemAddr),
    .ihit(ihit),
    .imemload(imemLoad),
    .iREN(iRen),
    .iaddr(iAddr),
    .iwait(iWait),
    .iload(iLoad)
  );

  // Memory model: each requested word is held off for waitCycles cycles.
  assign iWait = iRen && (waitCnt < waitCycles);
  assign iLoad = (iRen && !iWait) ? {16'hDEAD, iAddr[15:0]} : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (!iRen || !iWait) waitCnt <= 0;
    else waitCnt <= waitCnt + 1;
  end

  always @(negedge clk) begin
    if (iRen) begin
      renCount <= renCount + 1;
      if (!iWait) addrLog.push_back(iAddr);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ren, input logic [31:0] addr);
    imemRen  = ren;
    imemAddr = addr;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch and count cycles until ihit; optionally redirect in FILL0.
  task automatic fetchAndCheck(input string tag, input logic [31:0] addr, input int expLat,
                               input logic [31:0] expData, input bit doRedir = 1'b0,
                               input logic [31:0] redirAddr = 32'h0);
    int cycles = 0;
    applyStimulus(1'b1, addr);
    @(negedge clk);
    while (!ihit && cycles < 60) begin
      nextCycle();
      cycles++;
      if (doRedir && cycles == 1) applyStimulus(1'b1, redirAddr);
      @(negedge clk);
    end
    checkOutput({tag, "_lat"}, cycles, expLat);
    checkOutput({tag, "_data"}, imemLoad, expData);
    nextCycle();
  endtask

  initial begin
    nRst = 1'b0;
    applyStimulus(1'b1, 32'h0);
    waitCycles = 2;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_iren", iRen, 1'b0);
    checkOutput("reset_iaddr", iAddr, 32'h0);
    checkOutput("reset_ihit", ihit, 1'b0);
    checkOutput("reset_imemload", imemLoad, 32'h0);
    applyStimulus(1'b0, 32'h0);
    nRst = 1'b1;
    nextCycle();

    // cold miss with two wait cycles per word, then same-block hit
    logBase = addrLog.size();
    renBase = renCount;
    fetchAndCheck("t1_cold", 32'h00, 7, 32'hDEAD0000);
    checkOutput("t1_iaddr0", addrLog[logBase], 32'h00);
    checkOutput("t1_iaddr1", addrLog[logBase+1], 32'h04);
    checkOutput("t1_ren_cycles", renCount - renBase, 6);
    fetchAndCheck("t1_hit04", 32'h04, 0, 32'hDEAD0004);

    // zero-wait fill into way 1, then LRU-driven replacement
    waitCycles = 0;
    renBase = renCount;
    fetchAndCheck("t2_fill40", 32'h40, 3, 32'hDEAD0040);
    checkOutput("t6_ren_cycles", renCount - renBase, 2);
    fetchAndCheck("t2_hit00", 32'h00, 0, 32'hDEAD0000);
    fetchAndCheck("t2_fill80", 32'h80, 3, 32'hDEAD0080);
    fetchAndCheck("t2_keep00", 32'h00, 0, 32'hDEAD0000);
    fetchAndCheck("t2_evicted40", 32'h40, 3, 32'hDEAD0040);

    // redirect during FILL0: old fill completes, then the new address misses
    waitCycles = 2;
    logBase = addrLog.size();
    fetchAndCheck("t3_redir", 32'h100, 14, 32'hDEAD0200, 1'b1, 32'h200);
    checkOutput("t3_addr_a", addrLog[logBase], 32'h100);
    checkOutput("t3_addr_b", addrLog[logBase+1], 32'h104);
    checkOutput("t3_addr_c", addrLog[logBase+2], 32'h200);
    checkOutput("t3_addr_d", addrLog[logBase+3], 32'h204);
    fetchAndCheck("t3_hit100", 32'h100, 0, 32'hDEAD0100);

    // asynchronous reset in the middle of FILL1
    applyStimulus(1'b1, 32'h300);
    repeat (4) nextCycle();
    @(negedge clk);
    checkOutput("t4_fill1_iren", iRen, 1'b1);
    checkOutput("t4_fill1_iaddr", iAddr, 32'h304);
    #2 nRst = 1'b0;
    #1;
    checkOutput("t4_rst_iren", iRen, 1'b0);
    checkOutput("t4_rst_iaddr", iAddr, 32'h0);
    checkOutput("t4_rst_ihit", ihit, 1'b0);
    checkOutput("t4_rst_imemload", imemLoad, 32'h0);
    nextCycle();
    nRst = 1'b1;
    fetchAndCheck("t4_refetch", 32'h300, 7, 32'hDEAD0300);

    // idle reads of a resident line must not touch LRU or memory
    waitCycles = 0;
    fetchAndCheck("t5_fill00", 32'h00, 3, 32'hDEAD0000);
    applyStimulus(1'b0, 32'h300);
    renBase = renCount;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t5_idle_ihit", ihit, 1'b0);
      checkOutput("t5_idle_load", imemLoad, 32'h0);
      nextCycle();
    end
    checkOutput("t5_idle_ren", renCount - renBase, 0);
    fetchAndCheck("t5_fill40", 32'h40, 3, 32'hDEAD0040);
    fetchAndCheck("t5_lru_kept00", 32'h00, 0, 32'hDEAD0000);
    fetchAndCheck("t5_evicted300", 32'h300, 3, 32'hDEAD0300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
